// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor datapath and control unit.
package k_and_s_pkg;

   // Instruction classes handed to the control unit.
   typedef enum logic [3:0] {
      I_NOP    = 4'd0,
      I_LOAD   = 4'd1,
      I_STORE  = 4'd2,
      I_MOVE   = 4'd3,
      I_ADD    = 4'd4,
      I_SUB    = 4'd5,
      I_AND    = 4'd6,
      I_OR     = 4'd7,
      I_BRANCH = 4'd8,
      I_BZERO  = 4'd9,
      I_BNEG   = 4'd10,
      I_HALT   = 4'd11
   } decoded_instruction_type;

   // Registered ALU flags.
   typedef struct packed {
      logic zero;
      logic neg;
      logic unsigned_overflow;
      logic signed_overflow;
   } flags_t;

   // Opcodes live in IR[15:8].
   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_BRANCH = 8'h01;
   localparam logic [7:0] OP_BZERO  = 8'h02;
   localparam logic [7:0] OP_BNEG   = 8'h03;
   localparam logic [7:0] OP_LOAD   = 8'h81;
   localparam logic [7:0] OP_STORE  = 8'h82;
   localparam logic [7:0] OP_MOVE   = 8'h91;
   localparam logic [7:0] OP_ADD    = 8'hA1;
   localparam logic [7:0] OP_SUB    = 8'hA2;
   localparam logic [7:0] OP_AND    = 8'hA3;
   localparam logic [7:0] OP_OR     = 8'hA4;
   localparam logic [7:0] OP_HALT   = 8'hFF;

   // ALU operation codes driven by the control unit.
   localparam logic [1:0] ALU_OR  = 2'b00;
   localparam logic [1:0] ALU_ADD = 2'b01;
   localparam logic [1:0] ALU_SUB = 2'b10;
   localparam logic [1:0] ALU_AND = 2'b11;

   // Unknown opcodes decode as NOP so a corrupt fetch never writes state.
   function automatic decoded_instruction_type decode_opcode(input logic [7:0] opcode);
      decoded_instruction_type d;
      case (opcode)
         OP_BRANCH: d = I_BRANCH;
         OP_BZERO:  d = I_BZERO;
         OP_BNEG:   d = I_BNEG;
         OP_LOAD:   d = I_LOAD;
         OP_STORE:  d = I_STORE;
         OP_MOVE:   d = I_MOVE;
         OP_ADD:    d = I_ADD;
         OP_SUB:    d = I_SUB;
         OP_AND:    d = I_AND;
         OP_OR:     d = I_OR;
         OP_HALT:   d = I_HALT;
         default:   d = I_NOP;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/data_path_register_bank.sv
// 4x16 register bank: one synchronous write port, two combinational read ports.
// Reads see the pre-edge contents; a write appears on the read ports next cycle.
module register_bank
   import k_and_s_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we_i,
   input  logic [1:0]            waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [1:0]            raddr_a_i,
   input  logic [1:0]            raddr_b_i,
   output logic [DATA_WIDTH-1:0] rdata_a_o,
   output logic [DATA_WIDTH-1:0] rdata_b_o
);

   logic [DATA_WIDTH-1:0] regs_q [4];
   logic [DATA_WIDTH-1:0] regs_d [4];

   // Next-state: only the addressed register changes, and only on write enable.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (we_i) begin
         regs_d[waddr_i] = wdata_i;
      end
   end

   // Register storage with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/data_path.sv
// K&S processor datapath: PC, IR, register bank, ALU and flags register.
// The control unit drives every strobe; this block only reacts to them.
module data_path
   import k_and_s_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    branch,
   input  logic                    pc_enable,
   input  logic                    ir_enable,
   input  logic                    write_reg_enable,
   input  logic                    addr_sel,
   input  logic                    c_sel,
   input  logic [1:0]              operation,
   input  logic                    flags_reg_enable,
   output decoded_instruction_type decoded_instruction,
   output logic                    zero_op,
   output logic                    neg_op,
   output logic                    unsigned_overflow,
   output logic                    signed_overflow,
   output logic [ADDR_WIDTH-1:0]   ram_addr,
   output logic [DATA_WIDTH-1:0]   data_out,
   input  logic [DATA_WIDTH-1:0]   data_in
);

   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] ir_q, ir_d;
   flags_t                flags_q, flags_d, alu_flags;

   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [1:0]            raddr_a, raddr_b, waddr;
   logic [DATA_WIDTH-1:0] bus_a, bus_b, alu_result, wdata;
   logic [DATA_WIDTH:0]   sum_ext, diff_ext;

   // IR bit 7 is not part of any field in the current encoding.
   logic                  ir_bit7_unused;
   assign ir_bit7_unused = ir_q[7];

   assign mem_addr = ir_q[ADDR_WIDTH-1:0];

   // Instruction decode is purely combinational from IR.
   always_comb begin
      decoded_instruction = decode_opcode(ir_q[15:8]);
   end

   // Register addressing: STORE reads its data register on port A; MOVE
   // reads the source on both ports so ALU OR passes it through unchanged.
   always_comb begin
      raddr_a = ir_q[3:2];
      raddr_b = ir_q[1:0];
      waddr   = ir_q[5:4];
      case (decoded_instruction)
         I_STORE: raddr_a = ir_q[6:5];
         I_LOAD:  waddr   = ir_q[6:5];
         I_MOVE: begin
            raddr_a = ir_q[1:0];
            raddr_b = ir_q[1:0];
            waddr   = ir_q[3:2];
         end
         default: ;
      endcase
   end

   // ALU: 16-bit result, flags derived from the truncated result and operands.
   always_comb begin
      sum_ext    = {1'b0, bus_a} + {1'b0, bus_b};
      diff_ext   = {1'b0, bus_a} - {1'b0, bus_b};
      alu_result = '0;
      alu_flags  = '0;
      case (operation)
         ALU_ADD: begin
            alu_result                  = sum_ext[DATA_WIDTH-1:0];
            alu_flags.unsigned_overflow = sum_ext[DATA_WIDTH];
            alu_flags.signed_overflow   = (bus_a[DATA_WIDTH-1] == bus_b[DATA_WIDTH-1]) &&
                                          (alu_result[DATA_WIDTH-1] != bus_a[DATA_WIDTH-1]);
         end
         ALU_SUB: begin
            alu_result                  = diff_ext[DATA_WIDTH-1:0];
            alu_flags.unsigned_overflow = diff_ext[DATA_WIDTH];
            alu_flags.signed_overflow   = (bus_a[DATA_WIDTH-1] != bus_b[DATA_WIDTH-1]) &&
                                          (alu_result[DATA_WIDTH-1] != bus_a[DATA_WIDTH-1]);
         end
         ALU_AND: alu_result = bus_a & bus_b;
         default: alu_result = bus_a | bus_b;
      endcase
      alu_flags.zero = (alu_result == '0);
      alu_flags.neg  = alu_result[DATA_WIDTH-1];
   end

   assign wdata = c_sel ? alu_result : data_in;

   register_bank #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_register_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (write_reg_enable),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .raddr_a_i (raddr_a),
      .raddr_b_i (raddr_b),
      .rdata_a_o (bus_a),
      .rdata_b_o (bus_b)
   );

   // Next-state for PC, IR and flags; each holds unless its strobe is set.
   always_comb begin
      pc_d    = pc_q;
      ir_d    = ir_q;
      flags_d = flags_q;
      if (pc_enable) begin
         pc_d = branch ? pc_q + 1'b1 : mem_addr;
      end
      if (ir_enable) begin
         ir_d = data_in;
      end
      if (flags_reg_enable) begin
         flags_d = alu_flags;
      end
   end

   // PC, IR and flags registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         ir_q    <= '0;
         flags_q <= '0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
      end
   end

   assign ram_addr          = addr_sel ? mem_addr : pc_q;
   assign data_out          = bus_a;
   assign zero_op           = flags_q.zero;
   assign neg_op            = flags_q.neg;
   assign unsigned_overflow = flags_q.unsigned_overflow;
   assign signed_overflow   = flags_q.signed_overflow;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios then random strobes,
// compared against an arithmetic reference model of the datapath.
module tb_data_path;
   import k_and_s_pkg::*;

   logic                    clk;
   logic                    rst_n;
   logic                    branch, pc_enable, ir_enable, write_reg_enable;
   logic                    addr_sel, c_sel, flags_reg_enable;
   logic [1:0]              operation;
   decoded_instruction_type decoded_instruction;
   logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
   logic [4:0]              ram_addr;
   logic [15:0]             data_out, data_in;

   data_path #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .branch              (branch),
      .pc_enable           (pc_enable),
      .ir_enable           (ir_enable),
      .write_reg_enable    (write_reg_enable),
      .addr_sel            (addr_sel),
      .c_sel               (c_sel),
      .operation           (operation),
      .flags_reg_enable    (flags_reg_enable),
      .decoded_instruction (decoded_instruction),
      .zero_op             (zero_op),
      .neg_op              (neg_op),
      .unsigned_overflow   (unsigned_overflow),
      .signed_overflow     (signed_overflow),
      .ram_addr            (ram_addr),
      .data_out            (data_out),
      .data_in             (data_in)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model state ----------------
   int          m_pc;
   logic [15:0] m_ir;
   int          m_r [4];
   bit          m_z, m_n, m_u, m_s;

   int          tests_run = 0;
   int          fail_count = 0;
   logic [15:0] exp_q [$];

   task automatic model_reset();
      m_pc = 0;
      m_ir = 16'h0000;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
      m_z = 0; m_n = 0; m_u = 0; m_s = 0;
   endtask

   function automatic decoded_instruction_type model_decode(input logic [15:0] ir);
      case (ir[15:8])
         8'h01: return I_BRANCH;
         8'h02: return I_BZERO;
         8'h03: return I_BNEG;
         8'h81: return I_LOAD;
         8'h82: return I_STORE;
         8'h91: return I_MOVE;
         8'hA1: return I_ADD;
         8'hA2: return I_SUB;
         8'hA3: return I_AND;
         8'hA4: return I_OR;
         8'hFF: return I_HALT;
         default: return I_NOP;
      endcase
   endfunction

   function automatic int port_a(input logic [15:0] ir);
      if (ir[15:8] == 8'h82) return int'(ir[6:5]);
      if (ir[15:8] == 8'h91) return int'(ir[1:0]);
      return int'(ir[3:2]);
   endfunction

   function automatic int port_b(input logic [15:0] ir);
      return (ir[15:8] == 8'h91) ? port_a(ir) : int'(ir[1:0]);
   endfunction

   function automatic int wr_addr(input logic [15:0] ir);
      if (ir[15:8] == 8'h81) return int'(ir[6:5]);
      if (ir[15:8] == 8'h91) return int'(ir[3:2]);
      return int'(ir[5:4]);
   endfunction

   function automatic int to_signed16(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   // Arithmetic-level ALU: overflow judged by whether the true result fits.
   task automatic model_alu(input int op, input int a, input int b,
                            output int r, output bit z, output bit n,
                            output bit u, output bit s);
      int sa, sb, t;
      sa = to_signed16(a);
      sb = to_signed16(b);
      u = 0; s = 0;
      case (op)
         1: begin
            t = a + b; r = t % 65536; u = (t > 65535);
            s = (sa + sb > 32767) || (sa + sb < -32768);
         end
         2: begin
            r = (a - b + 65536) % 65536; u = (a < b);
            s = (sa - sb > 32767) || (sa - sb < -32768);
         end
         3: r = a & b;
         default: r = a | b;
      endcase
      z = (r == 0);
      n = (r >= 32768);
   endtask

   // ---------------- scoreboard ----------------
   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      tests_run++;
      if (got !== exp) begin
         fail_count++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string ph);
      int ea;
      ea = addr_sel ? int'(m_ir[4:0]) : m_pc;
      exp_q.push_back(16'(model_decode(m_ir)));
      exp_q.push_back(16'(m_z));
      exp_q.push_back(16'(m_n));
      exp_q.push_back(16'(m_u));
      exp_q.push_back(16'(m_s));
      exp_q.push_back(16'(ea));
      exp_q.push_back(16'(m_r[port_a(m_ir)]));
      check_eq({ph, "_dec"},  16'(decoded_instruction), exp_q.pop_front());
      check_eq({ph, "_zero"}, 16'(zero_op),             exp_q.pop_front());
      check_eq({ph, "_neg"},  16'(neg_op),              exp_q.pop_front());
      check_eq({ph, "_uovf"}, 16'(unsigned_overflow),   exp_q.pop_front());
      check_eq({ph, "_sovf"}, 16'(signed_overflow),     exp_q.pop_front());
      check_eq({ph, "_addr"}, 16'(ram_addr),            exp_q.pop_front());
      check_eq({ph, "_dout"}, data_out,                 exp_q.pop_front());
   endtask

   // One clock: model computes next state from pre-edge values, then compare.
   task automatic tick(input string ph);
      int np, nr[4], res;
      logic [15:0] ni;
      bit z, n, u, s;
      np = m_pc; ni = m_ir;
      for (int i = 0; i < 4; i++) nr[i] = m_r[i];
      model_alu(int'(operation), m_r[port_a(m_ir)], m_r[port_b(m_ir)], res, z, n, u, s);
      if (pc_enable) np = branch ? (m_pc + 1) % 32 : int'(m_ir[4:0]);
      if (ir_enable) ni = data_in;
      if (write_reg_enable) nr[wr_addr(m_ir)] = c_sel ? res : int'(data_in);
      @(posedge clk);
      #1;
      m_pc = np; m_ir = ni;
      for (int i = 0; i < 4; i++) m_r[i] = nr[i];
      if (flags_reg_enable) begin
         m_z = z; m_n = n; m_u = u; m_s = s;
      end
      check_outputs(ph);
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic br, input logic pe, input logic ie, input logic we,
                        input logic as_, input logic cs, input logic [1:0] op,
                        input logic fe, input logic [15:0] din, input string ph);
      branch = br; pc_enable = pe; ir_enable = ie; write_reg_enable = we;
      addr_sel = as_; c_sel = cs; operation = op; flags_reg_enable = fe;
      data_in = din;
      tick(ph);
   endtask

   task automatic load_ir(input logic [15:0] v, input logic as_);
      drive(0, 0, 1, 0, as_, 0, 2'b00, 0, v, "ir");
   endtask

   task automatic load_reg(input int n, input logic [15:0] v);
      load_ir(16'h8100 | 16'(n << 5), 0);
      drive(0, 0, 0, 1, 0, 0, 2'b00, 0, v, "ld");
   endtask

   task automatic read_reg(input int n, input logic [15:0] exp, input string tag);
      load_ir(16'h8200 | 16'(n << 5), 0);
      check_eq(tag, data_out, exp);
   endtask

   task automatic alu_op(input logic [15:0] ir, input logic [1:0] op);
      load_ir(ir, 0);
      drive(0, 0, 0, 1, 0, 1, op, 1, 16'h0000, "alu");
   endtask

   // ---------------- main sequence ----------------
   logic [7:0] op_list [12];

   initial begin
      op_list = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h81, 8'h82,
                  8'h91, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hFF};
      rst_n = 1'b0;
      branch = 0; pc_enable = 0; ir_enable = 0; write_reg_enable = 0;
      addr_sel = 0; c_sel = 0; operation = 2'b00; flags_reg_enable = 0;
      data_in = 16'h0000;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // LOAD decode and mem_addr, then write r0 from data_in.
      load_ir(16'h8103, 1);
      check_eq("load_dec", 16'(decoded_instruction), 16'(I_LOAD));
      check_eq("load_addr", 16'(ram_addr), 16'd3);
      drive(0, 0, 0, 1, 1, 0, 2'b00, 0, 16'h1234, "ld_r0");
      read_reg(0, 16'h1234, "r0_load");

      // ADD with signed overflow.
      load_reg(1, 16'h7FFF);
      load_reg(2, 16'h0001);
      alu_op(16'hA106, 2'b01);
      check_eq("add_neg", 16'(neg_op), 16'd1);
      check_eq("add_sovf", 16'(signed_overflow), 16'd1);
      check_eq("add_uovf", 16'(unsigned_overflow), 16'd0);
      check_eq("add_zero", 16'(zero_op), 16'd0);
      read_reg(0, 16'h8000, "add_r0");

      // SUB with borrow, then SUB to zero.
      load_reg(1, 16'h0000);
      load_reg(2, 16'h0001);
      alu_op(16'hA206, 2'b10);
      check_eq("sub_uovf", 16'(unsigned_overflow), 16'd1);
      check_eq("sub_neg", 16'(neg_op), 16'd1);
      check_eq("sub_sovf", 16'(signed_overflow), 16'd0);
      read_reg(0, 16'hFFFF, "sub_r0");
      load_reg(2, 16'h0000);
      alu_op(16'hA206, 2'b10);
      check_eq("sub0_zero", 16'(zero_op), 16'd1);
      read_reg(0, 16'h0000, "sub0_r0");

      // PC jump to 31, wrap on increment, jump to 17.
      load_ir(16'h011F, 0);
      drive(0, 1, 0, 0, 0, 0, 2'b00, 0, 16'h0000, "pc_jmp");
      check_eq("pc_31", 16'(ram_addr), 16'd31);
      drive(1, 1, 0, 0, 0, 0, 2'b00, 0, 16'h0000, "pc_inc");
      check_eq("pc_wrap", 16'(ram_addr), 16'd0);
      load_ir(16'h0111, 0);
      drive(0, 1, 0, 0, 0, 0, 2'b00, 0, 16'h0000, "pc_jmp17");
      check_eq("pc_17", 16'(ram_addr), 16'd17);

      // STORE addressing and MOVE through OR.
      load_reg(2, 16'hBEEF);
      load_ir(16'h8242, 1);
      check_eq("st_addr", 16'(ram_addr), 16'd2);
      check_eq("st_data", data_out, 16'hBEEF);
      load_ir(16'h910E, 0);
      drive(0, 0, 0, 1, 0, 1, 2'b00, 0, 16'h0000, "mov");
      read_reg(3, 16'hBEEF, "mov_r3");

      // Undefined opcode.
      load_ir(16'hCC00, 0);
      check_eq("undef_nop", 16'(decoded_instruction), 16'(I_NOP));

      // Asynchronous reset in the middle of an ALU cycle.
      load_ir(16'hA106, 0);
      branch = 1; pc_enable = 1; write_reg_enable = 1; c_sel = 1;
      operation = 2'b01; flags_reg_enable = 1; addr_sel = 0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("rst_mid");
      check_eq("rst_pc", 16'(ram_addr), 16'd0);
      check_eq("rst_dec", 16'(decoded_instruction), 16'(I_NOP));
      check_eq("rst_r0", data_out, 16'h0000);
      branch = 0; pc_enable = 0; write_reg_enable = 0; c_sel = 0;
      operation = 2'b00; flags_reg_enable = 0;
      @(negedge clk);
      rst_n = 1'b1;
      read_reg(1, 16'h0000, "rst_r1");
      read_reg(2, 16'h0000, "rst_r2");
      read_reg(3, 16'h0000, "rst_r3");

      // Random strobes and instructions.
      for (int k = 0; k < 400; k++) begin
         logic [15:0] din;
         din = 16'($urandom_range(0, 65535));
         if ($urandom_range(0, 1) == 1)
            din[15:8] = op_list[$urandom_range(0, 11)];
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), din, "rnd");
      end

      // ---------------- final report ----------------
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
      $finish;
   end

endmodule

// File: doc/data_path.md
Name: data_path

Overview:
- Datapath of the K&S processor; sits directly downstream of the control unit.
- Consumes the control unit's strobes and produces what the control unit consumes: decoded instruction and registered ALU flags.
- Holds PC, IR, a 4x16 register bank, the ALU and the flags register.
- Drives RAM address and write data, and accepts RAM read data.

Parameters:
- DATA_WIDTH, 16, word/instruction width (fixed at 16; the encoding depends on it)
- ADDR_WIDTH, 5, RAM address width (32 words)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- branch  in  1  PC source on pc_enable: 1 = PC+1, 0 = mem_addr
- pc_enable  in  1  load PC
- ir_enable  in  1  load IR from data_in
- write_reg_enable  in  1  write register bank
- addr_sel  in  1  ram_addr source: 0 = PC, 1 = mem_addr
- c_sel  in  1  write-back source: 0 = data_in, 1 = ALU result
- operation  in  2  ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
- flags_reg_enable  in  1  latch ALU flags
- decoded_instruction  out  decoded_instruction_type  decode of current IR
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags
- ram_addr  out  ADDR_WIDTH  RAM address
- data_out  out  16  RAM write data
- data_in  in  16  RAM read data

Behaviour:
- Reset (async): PC=0, IR=0x0000 (decodes I_NOP), r0..r3=0, all four flags=0. Outputs settle within the reset period.
- IR: on ir_enable, IR<=data_in. decoded_instruction is combinational from IR, valid the cycle after the load.
- Opcode is IR[15:8]:
  - 00000000 NOP; 00000001 BRANCH; 00000010 BZERO; 00000011 BNEG
  - 10000001 LOAD; 10000010 STORE; 10010001 MOVE
  - 10100001 ADD; 10100010 SUB; 10100011 AND; 10100100 OR
  - 11111111 HALT; any other value -> I_NOP
- Fields:
  - mem_addr = IR[4:0]
  - LOAD/STORE register = IR[6:5]
  - ALU ops: dest c = IR[5:4], a = IR[3:2], b = IR[1:0]
  - MOVE: dest = IR[3:2], src = IR[1:0]
- Read port A: IR[6:5] for STORE, IR[1:0] for MOVE, IR[3:2] otherwise.
- Read port B: IR[1:0] for ALU ops. For MOVE it equals port A, so OR yields the source value.
- Write address: IR[6:5] for LOAD, IR[3:2] for MOVE, IR[5:4] otherwise.
- data_out = port A, combinational.
- ram_addr = addr_sel ? mem_addr : PC, combinational.
- PC: on pc_enable, PC <= branch ? PC+1 : mem_addr. Increment wraps 31 -> 0.
- Register bank: on write_reg_enable, reg[waddr] <= c_sel ? alu_result : data_in. Writes are visible on read ports the next cycle; no bypass.
- ALU is combinational, 16-bit, result truncated. Flags are computed from the result:
  - zero = (result==0); neg = result[15]
  - ADD: unsigned_overflow = carry out of bit 15; signed_overflow = (a[15]==b[15]) && (r[15]!=a[15])
  - SUB (a-b): unsigned_overflow = borrow (a<b unsigned); signed_overflow = (a[15]!=b[15]) && (r[15]!=a[15])
  - AND/OR: both overflow flags 0
- Flags register: updates only on flags_reg_enable; otherwise holds. Flags are registered so BZERO/BNEG test the last latched ALU op.
- Simultaneous strobes: all enables are independent. Writing a register and latching flags on the same edge is legal; flags come from pre-edge operands.
- Reset mid-operation: all state returns to reset values immediately, regardless of strobes.

Decomposition:
- k_and_s_pkg holds:
  - decoded_instruction_type enum (I_NOP, I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_BRANCH, I_BZERO, I_BNEG, I_HALT)
  - 8-bit opcode localparams
  - ALU operation codes
- One sub-module: register_bank (4x16, one write port, two combinational read ports, async reset).
- Decoder, ALU, PC and flags stay inline.

Test Plan:
- Reset then ir_enable with data_in=0x8103 -> decoded_instruction=I_LOAD; addr_sel=1 gives ram_addr=3. Then data_in=0x1234, write_reg_enable=1, c_sel=0 -> r0=0x1234.
- r1=0x7FFF, r2=0x0001, IR=0xA106 (ADD r0=r1+r2), c_sel=1, op=01, flags_reg_enable -> r0=0x8000, neg=1, signed_overflow=1, unsigned_overflow=0, zero=0.
- r1=0x0000, r2=0x0001, IR=0xA206 (SUB), op=10 -> r0=0xFFFF, unsigned_overflow=1, neg=1, signed_overflow=0. Repeat with r2=0 -> zero=1.
- PC=31, pc_enable, branch=1 -> PC=0. IR=0x0111, branch=0, pc_enable -> PC=17.
- IR=0x8242 (STORE r2, addr 2), r2=0xBEEF, addr_sel=1 -> ram_addr=2, data_out=0xBEEF. IR=0x910E (MOVE r3<-r2), op=00, c_sel=1, write -> r3=0xBEEF.
- IR=0xCC00 -> I_NOP. Assert rst_n low mid-ALU cycle -> PC, IR, all registers and all flags read 0 at once.
